// File: rtl/tlb_refill_arbiter.sv
// Round-robin arbiter sharing the CP0 L2 TLB lookup port between the I-side and
// D-side micro-TLB refill paths, with retry on TLB update and flush-aware drop.

package tlb_refill_arbiter_pkg;

    typedef struct packed {
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
        logic        g;
    } tlb_entry;

endpackage

module tlb_refill_arbiter
    import tlb_refill_arbiter_pkg::*;
#(
    parameter int VPN2_W = 19
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [VPN2_W-1:0] i_vpn2,
    input  logic              i_cancel,
    output logic              i_ack,
    output logic              i_found,
    output tlb_entry          i_entry,
    input  logic              d_req,
    input  logic [VPN2_W-1:0] d_vpn2,
    input  logic              d_cancel,
    output logic              d_ack,
    output logic              d_found,
    output tlb_entry          d_entry,
    output logic [VPN2_W-1:0] l2_vpn2,
    input  logic              l2_found,
    input  tlb_entry          l2_entry,
    input  logic              tlb_update
);

    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;      // 0 = I-side, 1 = D-side
    logic              last_q, last_d;
    logic [VPN2_W-1:0] vpn2_q, vpn2_d;
    logic              found_q, found_d;
    tlb_entry          entry_q, entry_d;

    logic i_elig, d_elig, gnt_side, own_cancel, resp_vld;

    assign i_elig     = i_req & ~i_cancel;
    assign d_elig     = d_req & ~d_cancel;
    assign own_cancel = owner_q ? d_cancel : i_cancel;
    // On a tie the side that did not win last time goes next.
    assign gnt_side   = (i_elig & d_elig) ? ~last_q : d_elig;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            vpn2_q  <= '0;
            found_q <= 1'b0;
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            vpn2_q  <= vpn2_d;
            found_q <= found_d;
            entry_q <= entry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        vpn2_d  = vpn2_q;
        found_d = found_q;
        entry_d = entry_q;
        case (state_q)
            IDLE: begin
                if (i_elig | d_elig) begin
                    owner_d = gnt_side;
                    last_d  = gnt_side;
                    vpn2_d  = gnt_side ? d_vpn2 : i_vpn2;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                // A lookup overlapping an L2 update may see torn contents; retry it.
                if (own_cancel) begin
                    state_d = IDLE;
                end else if (!tlb_update) begin
                    found_d = l2_found;
                    entry_d = l2_found ? l2_entry : '0;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign resp_vld = (state_q == RESP) & ~own_cancel;
    assign i_ack    = resp_vld & ~owner_q;
    assign d_ack    = resp_vld & owner_q;
    assign i_found  = i_ack & found_q;
    assign d_found  = d_ack & found_q;
    assign i_entry  = i_ack ? entry_q : '0;
    assign d_entry  = d_ack ? entry_q : '0;
    assign l2_vpn2  = vpn2_q;

endmodule

// File: tb/tb_tlb_refill_arbiter.sv
// Directed test-plan steps followed by a randomized requester/L2 run, checked
// every cycle against a transaction-level model of the arbiter.

module tb_tlb_refill_arbiter;
    import tlb_refill_arbiter_pkg::*;

    localparam int W = 19;

    logic         clk = 1'b0;
    logic         resetn;
    logic         i_req, i_cancel, d_req, d_cancel;
    logic [W-1:0] i_vpn2, d_vpn2;
    logic         i_ack, i_found, d_ack, d_found;
    tlb_entry     i_entry, d_entry;
    logic [W-1:0] l2_vpn2;
    logic         l2_found, tlb_update;
    tlb_entry     l2_entry;

    tlb_refill_arbiter #(.VPN2_W(W)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_vpn2(i_vpn2), .i_cancel(i_cancel),
        .i_ack(i_ack), .i_found(i_found), .i_entry(i_entry),
        .d_req(d_req), .d_vpn2(d_vpn2), .d_cancel(d_cancel),
        .d_ack(d_ack), .d_found(d_found), .d_entry(d_entry),
        .l2_vpn2(l2_vpn2), .l2_found(l2_found), .l2_entry(l2_entry),
        .tlb_update(tlb_update)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: one outstanding transaction record plus the round-robin pointer.
    bit       m_busy, m_side, m_done, m_found, m_last;
    tlb_entry m_entry;
    logic [W-1:0] m_l2v;
    bit       ack_prev_i, ack_prev_d;

    // Values sampled in the most recent cycle, for directed assertions.
    logic     s_i_ack, s_d_ack, s_i_found, s_d_found;
    tlb_entry s_i_entry, s_d_entry;
    logic [W-1:0] s_l2v;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        m_busy = 0; m_side = 0; m_done = 0; m_found = 0; m_last = 0;
        m_entry = '0; m_l2v = '0; ack_prev_i = 0; ack_prev_d = 0;
    endtask

    // One clock cycle: inputs are already driven; check at negedge, advance the
    // model with this cycle's inputs, return just after the next posedge.
    task automatic cyc();
        bit own_c, e_rsp, e_i, e_d, ie, de, side;
        @(negedge clk);
        own_c = m_side ? d_cancel : i_cancel;
        e_rsp = m_busy && m_done && !own_c;
        e_i   = e_rsp && !m_side;
        e_d   = e_rsp && m_side;
        chk("i_ack",   i_ack,   e_i);
        chk("d_ack",   d_ack,   e_d);
        chk("i_found", i_found, e_i && m_found);
        chk("d_found", d_found, e_d && m_found);
        chk("i_entry", i_entry, e_i ? m_entry : tlb_entry'('0));
        chk("d_entry", d_entry, e_d ? m_entry : tlb_entry'('0));
        chk("l2_vpn2", l2_vpn2, m_l2v);
        s_i_ack = i_ack; s_d_ack = d_ack; s_i_found = i_found; s_d_found = d_found;
        s_i_entry = i_entry; s_d_entry = d_entry; s_l2v = l2_vpn2;
        ack_prev_i = e_i; ack_prev_d = e_d;
        if (!m_busy) begin
            ie = i_req && !i_cancel;
            de = d_req && !d_cancel;
            if (ie || de) begin
                side   = (ie && de) ? !m_last : de;
                m_busy = 1; m_done = 0; m_side = side; m_last = side;
                m_l2v  = side ? d_vpn2 : i_vpn2;
            end
        end else if (!m_done) begin
            if (own_c) m_busy = 0;
            else if (!tlb_update) begin
                m_done  = 1;
                m_found = l2_found;
                m_entry = l2_found ? l2_entry : '0;
            end
        end else begin
            m_busy = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // Random requester behaviour that respects the handshake rules.
    task automatic side_step(input bit grt, input bit acked, inout logic req,
                             inout logic cancel, inout logic [W-1:0] vpn);
        cancel = 0;
        if (req) begin
            if (acked) req = 0;
            else if (grt) begin
                if ($urandom_range(9) == 0) begin cancel = 1; req = 0; end
            end else begin
                case ($urandom_range(9))
                    0: begin cancel = 1; req = 0; end
                    1: req = 0;
                    2: vpn = W'($urandom);
                    default: ;
                endcase
            end
        end else begin
            if ($urandom_range(3) == 0) begin req = 1; vpn = W'($urandom); end
            else if ($urandom_range(19) == 0) cancel = 1;
        end
    endtask

    initial begin
        logic [63:0] r;
        tlb_entry    e;

        resetn = 0; i_req = 0; i_cancel = 0; d_req = 0; d_cancel = 0;
        i_vpn2 = '0; d_vpn2 = '0; l2_found = 0; tlb_update = 0; l2_entry = '0;
        mreset();
        #12;
        chk("rst_i_ack", i_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_i_entry", i_entry, 0);
        chk("rst_l2_vpn2", l2_vpn2, 0);
        @(posedge clk); #1;
        resetn = 1;

        // Single I-side hit.
        e = '0; e.pfn0 = 20'hABCDE; e.v0 = 1;
        i_req = 1; i_vpn2 = 19'h12345; l2_found = 1; l2_entry = e;
        cyc();
        cyc();
        chk("t1_l2_vpn2", s_l2v, 19'h12345);
        cyc();
        chk("t1_i_ack", s_i_ack, 1);
        chk("t1_i_found", s_i_found, 1);
        chk("t1_pfn0", s_i_entry.pfn0, 20'hABCDE);
        chk("t1_d_ack", s_d_ack, 0);
        i_req = 0;
        cyc();

        // Both held: D, I, D, I.
        i_req = 1; d_req = 1; i_vpn2 = 19'h00111; d_vpn2 = 19'h00222;
        for (int k = 0; k < 12; k++) begin
            cyc();
            if (k == 2)  chk("t2_d_first",  s_d_ack, 1);
            if (k == 5)  chk("t2_i_second", s_i_ack, 1);
            if (k == 8)  chk("t2_d_third",  s_d_ack, 1);
            if (k == 11) chk("t2_i_fourth", s_i_ack, 1);
        end
        i_req = 0; d_req = 0;
        cyc();

        // D-side miss with two retry cycles; stale entry on the bus must not leak.
        d_req = 1; d_vpn2 = 19'h7FFFF; l2_found = 0; l2_entry = '1;
        cyc();
        tlb_update = 1;
        cyc(); cyc();
        tlb_update = 0;
        cyc();
        cyc();
        chk("t3_d_ack", s_d_ack, 1);
        chk("t3_d_found", s_d_found, 0);
        chk("t3_d_entry", s_d_entry, 0);
        d_req = 0;
        cyc();

        // I cancelled in LOOKUP; pending D goes next.
        l2_found = 1; l2_entry = e;
        i_req = 1; d_req = 1; i_vpn2 = 19'h00333; d_vpn2 = 19'h00444;
        cyc();
        i_req = 0; i_cancel = 1;
        cyc();
        i_cancel = 0;
        cyc();
        chk("t4_grant_d", s_l2v, 19'h00333);
        cyc();
        chk("t4_l2_vpn2_d", s_l2v, 19'h00444);
        cyc();
        chk("t4_d_ack", s_d_ack, 1);
        chk("t4_i_ack", s_i_ack, 0);
        d_req = 0;
        cyc();

        // I cancelled in RESP: no ack, no retry.
        i_req = 1; i_vpn2 = 19'h00555;
        cyc(); cyc();
        i_cancel = 1;
        cyc();
        chk("t5_i_ack_suppr", s_i_ack, 0);
        i_cancel = 0; i_req = 0;
        cyc(); cyc(); cyc();
        chk("t5_no_retry", s_i_ack, 0);

        // Async reset mid-LOOKUP, then re-grant of the held D request.
        d_req = 1; d_vpn2 = 19'h00666;
        cyc();
        #2 resetn = 0;
        #1;
        chk("t6_rst_l2_vpn2", l2_vpn2, 0);
        chk("t6_rst_d_ack", d_ack, 0);
        chk("t6_rst_d_entry", d_entry, 0);
        mreset();
        @(posedge clk); #1;
        resetn = 1;
        cyc(); cyc(); cyc();
        chk("t6_d_ack", s_d_ack, 1);
        d_req = 0;
        cyc();

        // Randomized run.
        for (int n = 0; n < 3000; n++) begin
            side_step(m_busy && !m_side, ack_prev_i, i_req, i_cancel, i_vpn2);
            side_step(m_busy &&  m_side, ack_prev_d, d_req, d_cancel, d_vpn2);
            tlb_update = ($urandom_range(3) == 0);
            l2_found   = $urandom_range(1);
            r = {$urandom, $urandom};
            l2_entry = tlb_entry'(r[$bits(tlb_entry)-1:0]);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
